// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU constants for the writeback path: register address width, data
// width, the PC register index and the writeback requester ids.
package cpu_pkg;

  localparam int          REG_AW = 4;
  localparam int          DATA_W = 32;
  localparam logic [3:0]  PC_REG = 4'hF;

  typedef enum logic {
    WB_ALU  = 1'b0,
    WB_LOAD = 1'b1
  } wb_id_e;

  function automatic logic is_pc_addr(input logic [REG_AW-1:0] addr);
    return addr == PC_REG;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters, the register-file write port and
// the PC-update path.
interface rf_wb_arbiter_if #(
  parameter int DW = cpu_pkg::DATA_W,
  parameter int AW = cpu_pkg::REG_AW
);

  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          stall;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          pc_we;
  logic [DW-1:0] pc_wd;
  logic          busy;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output stall,
    input  req0_ready, req1_ready,
    input  rf_we, rf_wa, rf_wd, pc_we, pc_wd, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  stall,
    output req0_ready, req1_ready,
    output rf_we, rf_wa, rf_wd, pc_we, pc_wd, busy
  );

endinterface

// File: rtl/rf_wb_arbiter_wb_hold_slot.sv
// One-entry writeback holding register. A grant frees the slot in the same
// cycle, so a new request can be taken while the old one is being written.
module wb_hold_slot #(
  parameter int DW = cpu_pkg::DATA_W,
  parameter int AW = cpu_pkg::REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          grant,
  output logic          ready,
  output logic          accept,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  assign ready  = ~valid | grant;
  assign accept = in_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end

  // Payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr <= in_addr;
      data <= in_data;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: two holding slots share the single register-file write
// port, oldest-first with a round-robin tiebreak; r15 writes go to the PC.
module rf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int            DW      = DATA_W,
  parameter int            AW      = REG_AW,
  parameter logic [AW-1:0] PC_ADDR = PC_REG
) (
  input logic            clk,
  input logic            rst_n,
  rf_wb_arbiter_if.slave bus
);

  logic          v0, v1;
  logic          acc0, acc1;
  logic          g0, g1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  logic          age_v;
  logic          age_id;
  logic          rr_ptr;
  logic          tie_grant;
  logic          sel;

  logic          g_any;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  logic          g_to_pc;

  logic          rf_we_q, pc_we_q;
  logic [AW-1:0] rf_wa_q;
  logic [DW-1:0] rf_wd_q, pc_wd_q;

  logic          nv0, nv1;

  wb_hold_slot #(.DW(DW), .AW(AW)) u_slot0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.req0_valid),
    .in_addr  (bus.req0_addr),
    .in_data  (bus.req0_data),
    .grant    (g0),
    .ready    (bus.req0_ready),
    .accept   (acc0),
    .valid    (v0),
    .addr     (a0),
    .data     (d0)
  );

  wb_hold_slot #(.DW(DW), .AW(AW)) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.req1_valid),
    .in_addr  (bus.req1_addr),
    .in_data  (bus.req1_data),
    .grant    (g1),
    .ready    (bus.req1_ready),
    .accept   (acc1),
    .valid    (v1),
    .addr     (a1),
    .data     (d1)
  );

  // Grant: a lone entry wins; otherwise the older, or ~rr_ptr on a same-edge tie.
  always_comb begin
    g0        = 1'b0;
    g1        = 1'b0;
    tie_grant = 1'b0;
    sel       = WB_ALU;
    if (!bus.stall) begin
      if (v0 && !v1) begin
        g0 = 1'b1;
      end else if (v1 && !v0) begin
        g1 = 1'b1;
      end else if (v0 && v1) begin
        if (age_v) begin
          sel = age_id;
        end else begin
          sel       = ~rr_ptr;
          tie_grant = 1'b1;
        end
        g0 = (sel == WB_ALU);
        g1 = (sel == WB_LOAD);
      end
    end
  end

  assign nv0 = acc0 | (v0 & ~g0);
  assign nv1 = acc1 | (v1 & ~g1);

  // Age tracks which slot was captured first; a freshly accepted entry is always youngest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_v  <= 1'b0;
      age_id <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      if (tie_grant) rr_ptr <= g1;
      if (nv0 && nv1) begin
        if (acc0 && acc1) begin
          age_v  <= 1'b0;
          age_id <= 1'b0;
        end else if (acc0) begin
          age_v  <= 1'b1;
          age_id <= WB_LOAD;
        end else if (acc1) begin
          age_v  <= 1'b1;
          age_id <= WB_ALU;
        end
      end else begin
        age_v  <= 1'b0;
        age_id <= 1'b0;
      end
    end
  end

  assign g_any   = g0 | g1;
  assign g_addr  = g1 ? a1 : a0;
  assign g_data  = g1 ? d1 : d0;
  assign g_to_pc = (g_addr == PC_ADDR);

  // Output stage: one registered write per cycle, r15 steered to the PC path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      pc_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      pc_wd_q <= '0;
    end else begin
      rf_we_q <= g_any & ~g_to_pc;
      pc_we_q <= g_any & g_to_pc;
      if (g_any && !g_to_pc) begin
        rf_wa_q <= g_addr;
        rf_wd_q <= g_data;
      end
      if (g_any && g_to_pc) begin
        pc_wd_q <= g_data;
      end
    end
  end

  assign bus.rf_we = rf_we_q;
  assign bus.rf_wa = rf_wa_q;
  assign bus.rf_wd = rf_wd_q;
  assign bus.pc_we = pc_we_q;
  assign bus.pc_wd = pc_wd_q;
  assign bus.busy  = v0 | v1;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter: expected writes are queued as
// stimulus is issued and a negedge monitor checks every emitted strobe.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic        is_pc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  wr_t  exp_q[$];

  rf_wb_arbiter_if #(.DW(32), .AW(4)) bus ();

  rf_wb_arbiter #(.DW(32), .AW(4), .PC_ADDR(4'hF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (bus.rf_we || bus.pc_we)) begin
      vectors++;
      if (bus.rf_we && bus.pc_we) begin
        miscompares++;
        $display("FAIL dual_strobe: got rf_we=1 pc_we=1, expected one");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got pc=%0b addr=%h data=%h, expected none",
                 bus.pc_we, bus.rf_wa, bus.pc_we ? bus.pc_wd : bus.rf_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.is_pc != bus.pc_we ||
            (!e.is_pc && (e.addr != bus.rf_wa || e.data != bus.rf_wd)) ||
            (e.is_pc && e.data != bus.pc_wd)) begin
          miscompares++;
          $display("FAIL write_order: got pc=%0b addr=%h data=%h, expected pc=%0b addr=%h data=%h",
                   bus.pc_we, bus.rf_wa, bus.pc_we ? bus.pc_wd : bus.rf_wd,
                   e.is_pc, e.addr, e.data);
        end
      end
    end
  end

  task automatic push(input logic is_pc, input logic [3:0] a, input logic [31:0] d);
    wr_t e;
    e.is_pc = is_pc;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; presents the requests for exactly one edge.
  task automatic drive(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req1_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    bus.stall      = 1'b0;
    #12;
    check("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("rst_pc_we", {31'd0, bus.pc_we}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Single uncontested write: strobe for exactly the cycle after E1.
    push(1'b0, 4'd3, 32'hDEAD_BEEF);
    drive(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    check("single_e0_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("single_e0_busy",  {31'd0, bus.busy},  32'd1);
    @(negedge clk);
    check("single_e1_rf_we", {31'd0, bus.rf_we}, 32'd1);
    check("single_e1_rf_wa", {28'd0, bus.rf_wa}, 32'd3);
    check("single_e1_rf_wd", bus.rf_wd, 32'hDEAD_BEEF);
    check("single_e1_pc_we", {31'd0, bus.pc_we}, 32'd0);
    @(negedge clk);
    check("single_e2_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("single_e2_rf_wa_hold", {28'd0, bus.rf_wa}, 32'd3);
    check("single_e2_busy",  {31'd0, bus.busy},  32'd0);
    idle(1);

    // Async reset with slot 0 occupied: entry dropped, outputs cleared at once.
    bus.stall = 1'b1;
    drive(1'b1, 4'd7, 32'd77, 1'b0, 4'd0, 32'd0);
    check("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  {31'd0, bus.busy},  32'd0);
    check("arst_rf_wa", {28'd0, bus.rf_wa}, 32'd0);
    check("arst_rf_wd", bus.rf_wd, 32'd0);
    check("arst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("arst_pc_wd", bus.pc_wd, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.stall = 1'b0;
    idle(1);

    // Same-edge ties: rr_ptr=0 after reset so req1 first, then req0 first.
    push(1'b0, 4'd2, 32'd22);
    push(1'b0, 4'd1, 32'd11);
    drive(1'b1, 4'd1, 32'd11, 1'b1, 4'd2, 32'd22);
    idle(4);
    push(1'b0, 4'd1, 32'd11);
    push(1'b0, 4'd2, 32'd22);
    drive(1'b1, 4'd1, 32'd11, 1'b1, 4'd2, 32'd22);
    idle(4);

    // Age order on one address, both directions, captured under stall.
    bus.stall = 1'b1;
    push(1'b0, 4'd5, 32'd5);
    push(1'b0, 4'd5, 32'd9);
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'd5);
    drive(1'b1, 4'd5, 32'd9, 1'b0, 4'd0, 32'd0);
    bus.stall = 1'b0;
    idle(4);
    bus.stall = 1'b1;
    push(1'b0, 4'd6, 32'd1);
    push(1'b0, 4'd6, 32'd2);
    drive(1'b1, 4'd6, 32'd1, 1'b0, 4'd0, 32'd0);
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'd2);
    bus.stall = 1'b0;
    idle(4);

    // r15 goes to the PC path only.
    push(1'b1, 4'hF, 32'h100);
    drive(1'b1, 4'hF, 32'h100, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("pc_we",       {31'd0, bus.pc_we}, 32'd1);
    check("pc_wd",       bus.pc_wd, 32'h100);
    check("pc_rf_we",    {31'd0, bus.rf_we}, 32'd0);
    check("pc_rf_wa_keep", {28'd0, bus.rf_wa}, 32'd6);
    idle(2);

    // Stall with both slots full, then drain in two consecutive cycles.
    bus.stall = 1'b1;
    push(1'b0, 4'd9, 32'd90);
    push(1'b0, 4'd8, 32'd80);
    drive(1'b1, 4'd8, 32'd80, 1'b1, 4'd9, 32'd90);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rf_we", {31'd0, bus.rf_we}, 32'd0);
      check("stall_pc_we", {31'd0, bus.pc_we}, 32'd0);
      check("stall_rdy0",  {31'd0, bus.req0_ready}, 32'd0);
      check("stall_rdy1",  {31'd0, bus.req1_ready}, 32'd0);
      check("stall_busy",  {31'd0, bus.busy}, 32'd1);
    end
    @(posedge clk);
    #1 bus.stall = 1'b0;
    @(negedge clk);
    check("drain_rdy_resume", {31'd0, bus.req1_ready}, 32'd1);
    @(negedge clk);
    check("drain1_rf_we", {31'd0, bus.rf_we}, 32'd1);
    @(negedge clk);
    check("drain2_rf_we", {31'd0, bus.rf_we}, 32'd1);
    check("drain2_busy",  {31'd0, bus.busy},  32'd0);
    @(negedge clk);
    check("drain3_rf_we", {31'd0, bus.rf_we}, 32'd0);
    idle(2);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
